// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encodings, owner tags
// and fixed data patterns.
package mem_arb_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Which requester owns the outstanding transaction
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Read data returned on a response timeout
  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;
  localparam logic [3:0]  BE_ALL    = 4'hF;

  // Byte enables for a data-side access: stores use the requester's lanes,
  // loads always fetch the full word and let the core pick bytes.
  function automatic logic [3:0] data_be(input logic we, input logic [3:0] be);
    return we ? be : BE_ALL;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority select (data over fetch) with a starvation counter that
// hands the next arbitration to fetch after STARVE_LIMIT consecutive losses.
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve;
  logic       fetch_prio;

  assign fetch_prio = (starve == LIMIT);

  // Data wins ties unless fetch has been starved up to the limit
  always_comb begin
    pick_i = arb_en & i_req & (~d_req | fetch_prio);
    pick_d = arb_en & d_req & ~pick_i;
  end

  // Count fetch losses; a fetch win or an idle fetch side clears the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve <= '0;
    else if (!i_req || pick_i)
      starve <= '0;
    else if (pick_d && starve != LIMIT)
      starve <= starve + 4'd1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and load/store.
// One transaction in flight; response is routed back to its owner, and a
// response that never arrives is turned into an error ack after a timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic              owner;
  logic [TW-1:0]     tcnt;
  logic              pick_i, pick_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              i_err_q, d_err_q;
  logic              resp_done, resp_to;
  logic              unused_addr_lsb;

  // Byte offset bits are dropped: memory is word addressed
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == IDLE),
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  assign sel_addr  = pick_d ? d_addr : i_addr;
  assign resp_done = (state == WAIT) & m_rvalid;
  assign resp_to   = (state == WAIT) & ~m_rvalid & (tcnt == TLAST);

  assign m_req = (state == ISSUE);
  assign i_ack = (state == RESP) & (owner == OWN_I);
  assign d_ack = (state == RESP) & (owner == OWN_D);
  assign i_err = i_ack & i_err_q;
  assign d_err = d_ack & d_err_q;

  // Main sequencer: arbitrate, issue, wait for response, ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_I;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_i || pick_d) begin
          owner <= pick_d ? OWN_D : OWN_I;
          state <= ISSUE;
        end
        ISSUE: if (m_gnt) begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (resp_done || resp_to) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the winner's request fields; they stay put until the next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (pick_i || pick_d) begin
      m_we    <= pick_d & d_we;
      m_be    <= pick_d ? data_be(d_we, d_be) : BE_ALL;
      m_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
      m_wdata <= (pick_d && d_we) ? d_wdata : 32'h0;
    end
  end

  // Per-requester response data/error; held until that requester's next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else if (resp_done || resp_to) begin
      if (owner == OWN_I) begin
        i_rdata <= resp_done ? m_rdata : ERR_RDATA;
        i_err_q <= resp_to;
      end else begin
        d_rdata <= resp_done ? m_rdata : ERR_RDATA;
        d_err_q <= resp_to;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory by driving
// m_gnt/m_rvalid step by step and checks against hand-computed values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [31:0] hold_addr;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_m_fields", {m_we, m_be, m_addr}, 0);
    rst = 1'b0;
    tick();

    // ---------------- fetch only ----------------
    i_req = 1; i_addr = 32'h100; m_gnt = 1;
    tick();                                   // ISSUE
    chk("f_m_req", m_req, 1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_be_we", {m_be, m_we}, {4'hF, 1'b0});
    tick();                                   // WAIT
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h00500093;
    chk("f_wait_noreq", m_req, 0);
    chk("f_no_early_ack", i_ack, 0);
    tick();                                   // RESP, 3 cycles after i_req
    m_rvalid = 0;
    chk("f_i_ack", i_ack, 1);
    chk("f_i_rdata", i_rdata, 32'h00500093);
    chk("f_i_err", i_err, 0);
    chk("f_no_d_ack", d_ack, 0);
    i_req = 0;
    tick();                                   // IDLE
    chk("f_ack_pulse", i_ack, 0);
    chk("f_rdata_hold", i_rdata, 32'h00500093);

    // ---------------- simultaneous ----------------
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hA5A5;
    m_gnt = 1;
    tick();                                   // ISSUE (data)
    chk("s_d_addr", m_addr, 32'h200);
    chk("s_d_we_be", {m_we, m_be}, {1'b1, 4'h3});
    chk("s_d_wdata", m_wdata, 32'hA5A5);
    tick();                                   // WAIT
    m_rvalid = 1; m_rdata = 32'h0;
    tick();                                   // RESP
    m_rvalid = 0;
    chk("s_d_ack", {d_ack, i_ack, d_err}, 3'b100);
    d_req = 0; d_we = 0;
    tick();                                   // IDLE
    chk("s_idle_gap", m_req, 0);
    tick();                                   // ISSUE (fetch)
    chk("s_i_issue", {m_req, m_we, m_be}, {1'b1, 1'b0, 4'hF});
    chk("s_i_addr", m_addr, 32'h300);
    tick();                                   // WAIT
    m_rvalid = 1; m_rdata = 32'h11112222;
    tick();                                   // RESP
    m_rvalid = 0;
    chk("s_i_ack", {i_ack, d_ack}, 2'b10);
    chk("s_i_rdata", i_rdata, 32'h11112222);
    i_req = 0;
    tick();

    // ---------------- starvation ----------------
    d_req = 1; d_we = 0; d_addr = 32'h400;
    i_req = 1; i_addr = 32'h500;
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h55AA00FF;
    for (int k = 0; k < 5; k++) begin
      tick();                                 // ISSUE
      chk($sformatf("st_addr%0d", k), m_addr, (k < 4) ? 32'h400 : 32'h500);
      tick();                                 // WAIT
      tick();                                 // RESP
      chk($sformatf("st_ack%0d", k), {d_ack, i_ack}, (k < 4) ? 2'b10 : 2'b01);
      tick();                                 // IDLE
    end
    chk("st_d_rdata", d_rdata, 32'h55AA00FF);
    tick();                                   // ISSUE: counter restarted, data wins
    chk("st_reset_cnt", m_addr, 32'h400);
    tick(); tick();                           // RESP
    chk("st_last_ack", d_ack, 1);
    d_req = 0; i_req = 0; m_rvalid = 0;
    tick();

    // ---------------- timeout ----------------
    i_req = 1; i_addr = 32'h600; m_gnt = 1;
    tick();                                   // ISSUE
    tick();                                   // WAIT, first cycle
    m_gnt = 0;
    cnt = 0; seen = 0;
    while (!seen && cnt < 100) begin
      tick();
      cnt++;
      if (i_ack) seen = 1;
    end
    chk("to_ack_seen", seen, 1);
    chk("to_wait_cycles", cnt, 64);
    chk("to_err", i_err, 1);
    chk("to_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 0;
    tick();                                   // IDLE
    m_rvalid = 1; m_rdata = 32'h12345678;
    tick();
    chk("to_late_rvalid1", {i_ack, d_ack, m_req}, 0);
    tick();
    chk("to_late_rvalid2", {i_ack, d_ack, m_req}, 0);
    chk("to_rdata_kept", i_rdata, 32'hDEADBEEF);
    m_rvalid = 0;

    // ---------------- grant stall ----------------
    i_req = 1; i_addr = 32'h700; m_gnt = 0;
    tick();                                   // ISSUE
    hold_addr = m_addr;
    chk("gs_addr", hold_addr, 32'h700);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      i_addr = 32'h1000 + k;                  // post-latch changes must not leak
      tick();
      if (m_req === 1'b1 && m_addr === 32'h700 && i_ack === 1'b0) cnt++;
    end
    chk("gs_stable_cycles", cnt, 10);
    m_gnt = 1;
    tick();                                   // WAIT
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFE0001;
    tick();                                   // RESP
    m_rvalid = 0;
    chk("gs_ack", {i_ack, i_err}, 2'b10);
    chk("gs_rdata", i_rdata, 32'hCAFE0001);
    i_req = 0;
    tick();

    // ---------------- reset mid-WAIT ----------------
    d_req = 1; d_we = 1; d_be = 4'hC; d_addr = 32'h800; d_wdata = 32'h77; m_gnt = 1;
    tick();                                   // ISSUE
    tick();                                   // WAIT
    m_gnt = 0;
    #2 rst = 1;
    #1;
    chk("rw_m_outs", {m_req, m_we, m_be, m_addr, m_wdata}, 0);
    chk("rw_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rw_rdata", {i_rdata, d_rdata}, 0);
    d_req = 0; d_we = 0;
    tick();
    rst = 0;
    m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    tick();
    tick();
    chk("rw_no_ack", {i_ack, d_ack, m_req}, 0);
    m_rvalid = 0;
    i_req = 1; i_addr = 32'h900; m_gnt = 1;
    tick();                                   // ISSUE
    chk("rw_fresh_addr", m_addr, 32'h900);
    tick();                                   // WAIT
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D;
    tick();                                   // RESP
    m_rvalid = 0;
    chk("rw_fresh_ack", {i_ack, i_err, d_ack}, 3'b100);
    chk("rw_fresh_rdata", i_rdata, 32'h0BADF00D);
    i_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch path and the load/store path of the core.
- Accepts one transaction at a time from each requester and sequences it onto the memory port.
- Routes the response back to the requester that issued it.
- Data side has fixed priority; a starvation counter guarantees fetch progress.
- A response timeout returns an error instead of hanging the core.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins the next one (1..15).
- TIMEOUT_CYCLES, 64, cycles in WAIT without m_rvalid before an error response (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetch data
- i_err  out  1  qualifies i_ack; timeout occurred
- d_req  in  1  data request; held stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data
- d_err  out  1  qualifies d_ack; timeout occurred
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_be  out  4  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  32  memory write data
- m_gnt  in  1  memory accepts request this cycle
- m_rvalid  in  1  response for the outstanding request (reads and writes)
- m_rdata  in  32  memory read data

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; starve counter 0; timeout counter 0; owner cleared. Any in-flight transaction is abandoned. m_rvalid seen outside WAIT is ignored.
- State IDLE:
  - No request: stay in IDLE.
  - Request pending: arbitrate, latch the winner's fields into the m_* registers, record owner, go to ISSUE.
  - Both requesting: data wins unless starve counter == STARVE_LIMIT.
  - Starve counter: increments when fetch loses; cleared when fetch wins or i_req is low; saturates at STARVE_LIMIT.
- State ISSUE:
  - m_req = 1; m_* stable.
  - On m_gnt: m_req drops next cycle, timeout counter cleared, go to WAIT.
  - No timeout applies in ISSUE; memory may stall indefinitely.
- State WAIT:
  - m_req = 0; timeout counter increments each cycle.
  - On m_rvalid: capture m_rdata into the owner's rdata register and go to RESP.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without m_rvalid: rdata = 32'hDEADBEEF, set owner's err, go to RESP.
  - m_rvalid and timeout in the same cycle: m_rvalid wins, err = 0.
- State RESP:
  - Owner's ack = 1 for exactly one cycle; err valid with it.
  - rdata holds its value until the next response to that requester.
  - Return to IDLE. The requester may deassert req in the cycle ack is seen.
  - Next arbitration happens in IDLE the following cycle, so there are no back-to-back grants to the same requester without an IDLE cycle.
- Field mapping:
  - Fetch: m_we = 0, m_be = 4'hF, m_addr = {i_addr[ADDR_W-1:2], 2'b00}.
  - Data load: m_we = 0, m_be = 4'hF; the core extracts bytes.
  - Data store: m_we = 1, m_be = d_be, m_addr = {d_addr[ADDR_W-1:2], 2'b00}, m_wdata = d_wdata.
- Latency: requests are latched in IDLE, so changes to requester inputs after latch have no effect. Minimum req-to-ack latency is 3 cycles (IDLE, ISSUE with m_gnt, WAIT with m_rvalid, ack in RESP).
- Single outstanding transaction only.
- A store with d_be == 0 is still issued; memory treats it as no-op and must respond.

Decomposition:
- mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner encoding {OWN_I, OWN_D}
  - ERR_RDATA = 32'hDEADBEEF
  - BE_ALL = 4'hF
- Sub-module mem_arb_pick: combinational priority/starvation select, plus the starve counter register. The FSM, response routing and timeout counter stay in mem_arbiter.

Test Plan:
- Fetch only: i_req, i_addr = 0x100; m_gnt same cycle; m_rvalid next cycle with 0x00500093 -> m_addr = 0x100, m_be = F, m_we = 0; i_ack exactly 3 cycles after i_req with i_rdata = 0x00500093, i_err = 0; d_ack never asserts.
- Simultaneous: i_req + d_req (store 0x200, be = 4'b0011, wdata = 0xA5A5) -> data issued first with m_we = 1, m_be = 3; fetch issued immediately after d_ack + IDLE.
- Starvation: d_req held continuously (back-to-back loads), i_req held -> exactly STARVE_LIMIT = 4 data grants, then fetch granted on the 5th arbitration; counter then resets.
- Timeout: fetch granted, memory never asserts m_rvalid -> i_ack with i_err = 1, i_rdata = 0xDEADBEEF after TIMEOUT_CYCLES WAIT cycles. A late m_rvalid afterwards is ignored with no spurious ack.
- Gnt stall: m_gnt low for 10 cycles -> m_req and m_* stay stable; no timeout; ack follows normally once granted.
- Reset mid-WAIT: assert rst asynchronously in WAIT -> all outputs 0 immediately. m_rvalid after reset release produces no ack; a fresh i_req completes normally.
